ysyx_23060278_seq: RTL and testbench
====================================

# ysyx_23060278_seq

Multi-cycle instruction sequencer for the single-issue NPC core. Owns the PC and the instruction register, drives fetch and load/store handshakes, feeds the latched instruction to the decoder, and produces per-stage enables, register-file write strobe, halt/trap status and the retired-instruction count. The decoder, EXU and LSU are slaves sequenced by this block.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  out  1  fetch request; Moore output of state
- ifu_req_ready  in  1  instruction memory accepts request
- ifu_addr  out  32  fetch address (= pc)
- ifu_rsp_valid  in  1  fetch data valid
- ifu_rsp_data  in  32  fetched instruction
- ifu_rsp_err  in  1  fetch access fault, qualified by ifu_rsp_valid
- inst  out  32  instruction register to decoder
- opcode  in  7  decoder opcode for inst
- next_pc  in  32  EXU-computed next PC, valid in WB
- lsu_req_valid  out  1  load/store request
- lsu_req_ready  in  1  LSU accepts request
- lsu_rsp_valid  in  1  LSU access complete
- pc  out  32  current instruction address
- rf_we  out  1  register-file write strobe (one cycle, WB only)
- halt  out  1  sticky, core stopped
- trap_err  out  1  sticky, halt caused by fault
- instret  out  64  retired-instruction count

## Operation
- States: IDLE, FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT. Reset enters IDLE.
- IDLE: all requests low; next cycle -> FETCH.
- FETCH: ifu_req_valid=1, ifu_addr=pc; held stable until ifu_req_ready=1 -> FWAIT.
- FWAIT: wait for ifu_rsp_valid. err=1 -> HALT, trap_err=1, inst unchanged. Else inst<=ifu_rsp_data -> DECODE.
- DECODE: one cycle for decoder outputs to settle -> EXEC.
- EXEC: one cycle. inst==32'h0010_0073 (ebreak) -> HALT, trap_err=0. opcode 0000011/0100011 -> MEM. Else -> WB.
- MEM: lsu_req_valid=1 until lsu_req_ready -> MWAIT. MWAIT: on lsu_rsp_valid -> WB.
- WB: rf_we=1 iff opcode in {0110111,0010111,1101111,1100111,0000011,0010011,0110011,0011011,0111011}. next_pc[1:0]!=0 -> HALT, trap_err=1, pc unchanged, instret unchanged, rf_we still asserted. Else pc<=next_pc, instret+=1, -> FETCH.
- HALT: all requests and rf_we low; exits only on rst.
- ifu_rsp_valid/lsu_rsp_valid ignored outside FWAIT/MWAIT; ready inputs ignored when corresponding valid is low.
- instret wraps 2^64-1 -> 0.

## Timing
- Reset values: state IDLE, pc=RESET_PC, inst=32'h0000_0013, instret=0, halt=0, trap_err=0, ifu_req_valid=0, lsu_req_valid=0, rf_we=0.
- rst mid-transaction: immediate return to reset values; any outstanding response is dropped by the FWAIT/MWAIT qualification.
- First fetch request asserted cycle 1 after rst deasserts.
- Zero-wait memories (ready and rsp_valid high the cycle after entry): ALU/branch instruction 5 cycles FETCH->FETCH; load/store 7 cycles.
- Request and response in the same cycle as ready are not accepted: response is sampled only from the cycle after the handshake.
- All outputs are functions of registered state/data only; no input-to-output combinational path.

## Structure
- Package ysyx_23060278_pkg: state encoding, opcode constants, EBREAK encoding, NOP encoding, default RESET_PC.
- Sub-module ysyx_23060278_opclass: combinational opcode -> {is_mem, writes_rd, is_ebreak}; instantiated once.

## Test plan
- Reset then ADDI 32'h0010_0093 at 0x8000_0000, zero-wait memory, next_pc=0x8000_0004 -> ifu_addr=0x8000_0000 cycle 1, rf_we pulse cycle 5, pc=0x8000_0004, instret=1, next fetch cycle 6.
- Load 32'h0000_2103 with lsu_req_ready delayed 3 cycles and lsu_rsp_valid 2 further cycles -> lsu_req_valid held 4 cycles, rf_we exactly once after rsp, instret=1.
- ifu_rsp_err=1 on first fetch -> halt=1, trap_err=1, inst=32'h0000_0013, no further requests for 20 cycles.
- ebreak 32'h0010_0073 -> halt=1, trap_err=0, rf_we never asserted, instret unchanged.
- JAL with next_pc=0x8000_0102 -> trap_err=1, pc stays 0x8000_0000; then assert rst during a pending fetch with a late ifu_rsp_valid -> pc=RESET_PC, response ignored, clean refetch.

Source files
------------

// File: rtl/ysyx_23060278_pkg.sv
// Shared definitions for the NPC instruction sequencer: state encoding,
// RV64 major opcodes that matter to sequencing, and fixed encodings.
package ysyx_23060278_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    FWAIT,
    DECODE,
    EXEC,
    MEM,
    MWAIT,
    WB,
    HALT
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;

  // Opcodes whose instructions produce a destination-register result
  function automatic logic op_writes_rd(input logic [6:0] op);
    logic wr;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_OP_IMM, OP_OP, OP_OP_IMM_32, OP_OP_32: wr = 1'b1;
      default:                                  wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/ysyx_23060278_opclass.sv
// Classifies the decoded instruction for the sequencer: whether it needs
// the LSU, whether it writes rd, and whether it is ebreak.
module ysyx_23060278_opclass
  import ysyx_23060278_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] inst,
  output logic        is_mem,
  output logic        writes_rd,
  output logic        is_ebreak
);

  // Pure decode of the opcode class and the full ebreak encoding
  always_comb begin
    is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
    writes_rd = op_writes_rd(opcode);
    is_ebreak = (inst == INST_EBREAK);
  end

endmodule

// File: rtl/ysyx_23060278_seq.sv
// Multi-cycle sequencer for the single-issue NPC core. Owns pc, the
// instruction register and the retired count, and walks each instruction
// through fetch, decode, execute, optional memory access and writeback.
// The decoder's class is captured at the end of DECODE so that no output
// depends combinationally on an input.
module ysyx_23060278_seq
  import ysyx_23060278_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  input  logic        ifu_rsp_err,
  output logic [31:0] inst,
  input  logic [6:0]  opcode,
  input  logic [31:0] next_pc,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic        halt,
  output logic        trap_err,
  output logic [63:0] instret
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [63:0] instret_q;
  logic        trap_q;
  logic        cls_mem_q;
  logic        cls_wr_q;
  logic        dec_mem;
  logic        dec_wr;
  logic        dec_ebreak;
  logic        wb_misaligned;

  ysyx_23060278_opclass u_opclass (
    .opcode    (opcode),
    .inst      (inst_q),
    .is_mem    (dec_mem),
    .writes_rd (dec_wr),
    .is_ebreak (dec_ebreak)
  );

  assign wb_misaligned = (next_pc[1:0] != 2'b00);

  assign ifu_addr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign instret  = instret_q;
  assign trap_err = trap_q;

  // State register; reset always lands in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection and Moore handshake/strobe outputs
  always_comb begin
    state_nxt     = state;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_we         = 1'b0;
    halt          = 1'b0;
    case (state)
      IDLE:   state_nxt = FETCH;
      FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_nxt = FWAIT;
      end
      FWAIT: begin
        if (ifu_rsp_valid) state_nxt = ifu_rsp_err ? HALT : DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (dec_ebreak)     state_nxt = HALT;
        else if (cls_mem_q) state_nxt = MEM;
        else                state_nxt = WB;
      end
      MEM: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) state_nxt = MWAIT;
      end
      MWAIT: begin
        if (lsu_rsp_valid) state_nxt = WB;
      end
      WB: begin
        rf_we     = cls_wr_q;
        state_nxt = wb_misaligned ? HALT : FETCH;
      end
      HALT: begin
        halt      = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Architectural datapath: instruction capture, class latch, pc/instret update, trap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inst_q    <= INST_NOP;
      instret_q <= 64'd0;
      trap_q    <= 1'b0;
      cls_mem_q <= 1'b0;
      cls_wr_q  <= 1'b0;
    end else begin
      if (state == FWAIT && ifu_rsp_valid) begin
        if (ifu_rsp_err) trap_q <= 1'b1;
        else             inst_q <= ifu_rsp_data;
      end
      if (state == DECODE) begin
        cls_mem_q <= dec_mem;
        cls_wr_q  <= dec_wr;
      end
      if (state == WB) begin
        if (wb_misaligned) begin
          trap_q <= 1'b1;
        end else begin
          pc_q      <= next_pc;
          instret_q <= instret_q + 64'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060278_seq.sv
// Randomized scoreboard bench for the NPC sequencer. The stimulus side plays
// instruction memory, decoder, EXU and LSU, and predicts each architectural
// outcome; the monitor checks those predictions at every new fetch request
// and at the moment the core halts.
module tb_ysyx_23060278_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] next_pc;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [31:0] pc;
  logic        rf_we;
  logic        halt;
  logic        trap_err;
  logic [63:0] instret;

  always #5 clk = ~clk;

  ysyx_23060278_seq dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .inst          (inst),
    .opcode        (opcode),
    .next_pc       (next_pc),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .pc            (pc),
    .rf_we         (rf_we),
    .halt          (halt),
    .trap_err      (trap_err),
    .instret       (instret)
  );

  typedef struct {
    bit          is_halt;
    logic [31:0] pc;
    logic [63:0] instret;
    bit          trap;
    int          we;
    logic [31:0] inst;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_model;
  logic [31:0] inst_model;
  logic [63:0] instret_model;
  bit          zero_wait;

  logic [6:0] OPS [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                           7'b0011011, 7'b0111011, 7'b1100011, 7'b0001111,
                           7'b1110011};

  function automatic bit writes_rd_ref(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                      7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit is_halt, input logic [31:0] epc, input logic [63:0] eret,
                         input bit trap, input int we, input logic [31:0] einst, input int gap);
    exp_t e;
    e.is_halt = is_halt;
    e.pc      = epc;
    e.instret = eret;
    e.trap    = trap;
    e.we      = we;
    e.inst    = einst;
    e.gap     = gap;
    sb.push_back(e);
  endtask

  // Monitor: each new fetch request or halt entry retires one scoreboard entry
  bit prev_req;
  bit prev_halt;
  int we_cnt;
  int gap_cnt;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_req  = 1'b0;
      prev_halt = 1'b0;
      we_cnt    = 0;
      gap_cnt   = 0;
    end else begin
      gap_cnt++;
      if (rf_we) we_cnt++;
      if ((ifu_req_valid && !prev_req) || (halt && !prev_halt)) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("event_is_halt", 64'(halt), 64'(e.is_halt));
          checkOutput("pc", 64'(pc), 64'(e.pc));
          if (!e.is_halt) checkOutput("ifu_addr", 64'(ifu_addr), 64'(e.pc));
          checkOutput("instret", instret, e.instret);
          checkOutput("trap_err", 64'(trap_err), 64'(e.trap));
          checkOutput("inst", 64'(inst), 64'(e.inst));
          checkOutput("rf_we_pulses", 64'(we_cnt), 64'(e.we));
          if (e.gap > 0) checkOutput("fetch_to_fetch_cycles", 64'(gap_cnt), 64'(e.gap));
        end
        we_cnt = 0;
        if (ifu_req_valid && !prev_req) gap_cnt = 0;
      end
      prev_req  = ifu_req_valid;
      prev_halt = halt;
    end
  end

  task automatic doReset(input bit late_rsp);
    checkOutput("sb_empty_before_reset", 64'(sb.size()), 64'd0);
    rst           = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    sb.delete();
    pc_model      = RST_PC;
    inst_model    = NOP;
    instret_model = 64'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pc", 64'(pc), 64'(RST_PC));
    checkOutput("rst_inst", 64'(inst), 64'(NOP));
    checkOutput("rst_instret", instret, 64'd0);
    checkOutput("rst_flags", {60'd0, halt, trap_err, ifu_req_valid, lsu_req_valid}, 64'd0);
    checkOutput("rst_rf_we", 64'(rf_we), 64'd0);
    pushExp(1'b0, RST_PC, 64'd0, 1'b0, 0, NOP, 0);
    rst = 1'b0;
    if (late_rsp) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_err   = 1'b1;
      ifu_rsp_data  = 32'hbad0_0bad;
    end
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    checkOutput("first_fetch_cycle1", 64'(ifu_req_valid), 64'd1);
  endtask

  // One instruction: fetch handshake, response, optional LSU, halt follow-up
  task automatic applyStimulus(input bit allow_halt, input int force_kind,
                               output bit halted, output bit ok);
    int          d;
    int          pick;
    logic [31:0] tmp;
    logic [31:0] data;
    logic [31:0] npc;
    logic [6:0]  opc;
    bit          err;
    bit          is_eb;
    bit          mis;
    bit          is_mem;
    bit          w;
    bit          bad;
    halted = 1'b0;
    ok     = 1'b1;
    d = 0;
    while (!ifu_req_valid && d < 50) begin @(negedge clk); d++; end
    if (!ifu_req_valid) begin
      checkOutput("fetch_req_timeout", 64'(ifu_req_valid), 64'd1);
      ok = 1'b0;
      return;
    end
    pick  = $urandom_range(0, 99);
    err   = (force_kind == 1) || (allow_halt && pick < 3);
    is_eb = !err && ((force_kind == 2) || (allow_halt && pick >= 3 && pick < 6));
    mis   = (force_kind == 3) || (allow_halt && pick >= 6 && pick < 9);
    if (is_eb) begin
      data = EBREAK;
    end else begin
      opc = (force_kind == 3) ? 7'b1101111 : OPS[$urandom_range(0, 12)];
      tmp = $urandom();
      data = {tmp[31:7], opc};
      if (data == EBREAK) data = data ^ 32'h0000_1000;
    end
    if (mis) npc = pc_model + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
    else     npc = pc_model + 32'($urandom_range(0, 127)) * 32'd4 - 32'd256;
    is_mem = !err && !is_eb && (data[6:0] == 7'b0000011 || data[6:0] == 7'b0100011);

    repeat (zero_wait ? 0 : $urandom_range(0, 3)) @(negedge clk);
    checkOutput("ifu_req_held", 64'(ifu_req_valid), 64'd1);
    checkOutput("ifu_addr_held", 64'(ifu_addr), 64'(pc_model));
    ifu_req_ready = 1'b1;
    if (!zero_wait && $urandom_range(0, 1) == 1) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_err   = 1'b1;
      ifu_rsp_data  = 32'hdead_beef;
    end
    @(negedge clk);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    repeat (zero_wait ? 0 : $urandom_range(0, 3)) @(negedge clk);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_err   = err;
    ifu_rsp_data  = data;
    opcode        = data[6:0];
    next_pc       = npc;

    if (err) begin
      pushExp(1'b1, pc_model, instret_model, 1'b1, 0, inst_model, 0);
    end else begin
      inst_model = data;
      w = writes_rd_ref(data[6:0]);
      if (is_eb) begin
        pushExp(1'b1, pc_model, instret_model, 1'b0, 0, data, 0);
      end else if (mis) begin
        pushExp(1'b1, pc_model, instret_model, 1'b1, w ? 1 : 0, data, 0);
      end else begin
        pc_model      = npc;
        instret_model = instret_model + 64'd1;
        pushExp(1'b0, pc_model, instret_model, 1'b0, w ? 1 : 0, data,
                zero_wait ? (is_mem ? 7 : 5) : 0);
      end
    end
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    if (!zero_wait && !err && $urandom_range(0, 2) == 0) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_err   = 1'b1;
      @(negedge clk);
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
    end

    if (is_mem) begin
      d = 0;
      while (!lsu_req_valid && d < 50) begin @(negedge clk); d++; end
      if (!lsu_req_valid) begin
        checkOutput("lsu_req_timeout", 64'(lsu_req_valid), 64'd1);
        ok = 1'b0;
        return;
      end
      repeat (zero_wait ? 0 : $urandom_range(0, 3)) @(negedge clk);
      checkOutput("lsu_req_held", 64'(lsu_req_valid), 64'd1);
      lsu_req_ready = 1'b1;
      if (!zero_wait && $urandom_range(0, 1) == 1) lsu_rsp_valid = 1'b1;
      @(negedge clk);
      lsu_req_ready = 1'b0;
      lsu_rsp_valid = 1'b0;
      repeat (zero_wait ? 0 : $urandom_range(0, 3)) @(negedge clk);
      checkOutput("lsu_no_wb_before_rsp", 64'(rf_we), 64'd0);
      lsu_rsp_valid = 1'b1;
      @(negedge clk);
      lsu_rsp_valid = 1'b0;
    end

    if (err || is_eb || mis) begin
      d = 0;
      while (!halt && d < 20) begin @(negedge clk); d++; end
      checkOutput("halt_reached", 64'(halt), 64'd1);
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ifu_req_valid || lsu_req_valid || rf_we || !halt) bad = 1'b1;
      end
      checkOutput("halt_quiet_20", 64'(bad), 64'd0);
      halted = 1'b1;
    end
  endtask

  initial begin
    bit halted;
    bit ok;
    int fk;
    rst           = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    ifu_rsp_data  = 32'd0;
    opcode        = 7'd0;
    next_pc       = 32'd0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    for (int run = 0; run < 10; run++) begin
      zero_wait = (run < 2);
      doReset(run > 0);
      halted = 1'b0;
      ok     = 1'b1;
      for (int i = 0; i < 25 && !halted && ok; i++) begin
        fk = 0;
        if (run == 2 && i == 0) fk = 1;
        if (run == 3 && i == 3) fk = 2;
        if (run == 4 && i == 3) fk = 3;
        applyStimulus(run >= 5, fk, halted, ok);
      end
      if (ok && !halted) begin
        for (int d = 0; d < 50 && !ifu_req_valid; d++) @(negedge clk);
        checkOutput("pending_fetch_req", 64'(ifu_req_valid), 64'd1);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
      end
    end
    doReset(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
